serial_adder: RTL

Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock through a single registered carry, so area is traded for latency. The block sits beside the combinational adder cells in the arithmetic library and serves datapaths that can tolerate a WIDTH/DIGIT-cycle result. It adds a Start/Busy/Done handshake, a subtract mode and signed-overflow detection.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_digit_adder.sv | 29 ++
 rtl/serial_adder.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the digit-serial adder/subtractor: FSM state
// encodings and the counter-width helper.
package serial_adder_pkg;

  // FSM state encodings; 2'd3 is unused and recovers to ST_IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Digit counter width: clog2(n), but never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder slice used by serial_adder.
// Also exports the carry into its top bit so the caller can form
// two's-complement overflow on the final digit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // Ripple the carry through the digit, tapping it before the top bit.
  always_comb begin
    logic c;
    c        = ci;
    c_msb_in = ci;
    s        = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits
// per clock through one registered carry, with start/busy/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands latched on the accepting edge
// ST_RUN  | one digit per edge, LSB first; result committed on last edge
// ST_DONE | done pulse, result valid; returns to ST_IDLE unconditionally
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [WIDTH-1:0] res;

  logic [DIGIT-1:0]       d_s;
  logic                   d_co;
  logic                   d_msb;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic                   last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (sa[DIGIT-1:0]),
    .b        (sb[DIGIT-1:0]),
    .ci       (carry),
    .s        (d_s),
    .co       (d_co),
    .c_msb_in (d_msb)
  );

  // New digit enters at the MSB end; the concatenation keeps this legal
  // even when a single digit covers the whole word.
  assign res_cat  = {d_s, res};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = (cnt == CW'(N - 1));

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

  // FSM, operand shift registers, carry, counter and committed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sa       <= '0;
      sb       <= '0;
      carry    <= 1'b0;
      res      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa    <= sa >> DIGIT;
          sb    <= sb >> DIGIT;
          carry <= d_co;
          res   <= res_next;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum      <= res_next;
            cout     <= d_co;
            overflow <= d_co ^ d_msb;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
